// File: rtl/register_file_2r1w.sv
// Two-read/one-write register file with per-entry valid bits, registered reads
// with write-first bypass, and a one-entry-per-cycle clear sequencer.
module register_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic [ADDR_WIDTH-1:0] rAddr0,
  input  logic [ADDR_WIDTH-1:0] rAddr1,
  output logic [DATA_WIDTH-1:0] rData0,
  output logic [DATA_WIDTH-1:0] rData1,
  output logic                  rValid0,
  output logic                  rValid1,
  input  logic                  clr_start,
  output logic                  busy,
  output logic                  wr_drop
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        valid;
  logic                    wr_ok;
  logic                    rd0_hit_wr, rd0_hit_clr;
  logic                    rd1_hit_wr, rd1_hit_clr;

  assign busy  = (state == CLEAR);
  assign wr_ok = we & ~busy;

  // A write and a sweep never target the array in the same cycle, so the
  // bypass priority below only matters for readability.
  assign rd0_hit_wr  = wr_ok && (wAddr == rAddr0);
  assign rd1_hit_wr  = wr_ok && (wAddr == rAddr1);
  assign rd0_hit_clr = busy && (ptr == rAddr0);
  assign rd1_hit_clr = busy && (ptr == rAddr1);

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        ptr_next = ptr + 1'b1;
        if (ptr == LAST_ADDR) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]   <= '0;
        valid[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && (wAddr == ADDR_WIDTH'(i))) begin
          mem[i]   <= wData;
          valid[i] <= 1'b1;
        end else if (busy && (ptr == ADDR_WIDTH'(i))) begin
          mem[i]   <= '0;
          valid[i] <= 1'b0;
        end
      end
    end
  end

  // Registered read ports: write-first, then clear-first, then array contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rData0  <= '0;
      rData1  <= '0;
      rValid0 <= 1'b0;
      rValid1 <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      if (rd0_hit_wr) begin
        rData0  <= wData;
        rValid0 <= 1'b1;
      end else if (rd0_hit_clr) begin
        rData0  <= '0;
        rValid0 <= 1'b0;
      end else begin
        rData0  <= mem[rAddr0];
        rValid0 <= valid[rAddr0];
      end

      if (rd1_hit_wr) begin
        rData1  <= wData;
        rValid1 <= 1'b1;
      end else if (rd1_hit_clr) begin
        rData1  <= '0;
        rValid1 <= 1'b0;
      end else begin
        rData1  <= mem[rAddr1];
        rValid1 <= valid[rAddr1];
      end

      wr_drop <= we & busy;
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: default instance (32x8) and an overridden
// instance (16x16) share stimulus; sel chooses which one is driven and checked.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic        clr_start = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic [3:0]  r_addr0 = '0;
  logic [3:0]  r_addr1 = '0;

  logic [31:0] a_rdata0, a_rdata1;
  logic        a_rvalid0, a_rvalid1, a_busy, a_wr_drop;
  logic [15:0] b_rdata0, b_rdata1;
  logic        b_rvalid0, b_rvalid1, b_busy, b_wr_drop;

  logic [31:0] obs_d0, obs_d1;
  logic        obs_v0, obs_v1, obs_busy, obs_drop;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d0;
    logic        v0;
    logic [31:0] d1;
    logic        v1;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  logic [31:0] m_mem [16];
  logic        m_val [16];
  logic        m_busy;
  int          m_ptr;

  always #5 clk = ~clk;

  register_file_2r1w u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .we        (we & ~sel),
    .wAddr     (w_addr[2:0]),
    .wData     (w_data),
    .rAddr0    (r_addr0[2:0]),
    .rAddr1    (r_addr1[2:0]),
    .rData0    (a_rdata0),
    .rData1    (a_rdata1),
    .rValid0   (a_rvalid0),
    .rValid1   (a_rvalid1),
    .clr_start (clr_start & ~sel),
    .busy      (a_busy),
    .wr_drop   (a_wr_drop)
  );

  register_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .we        (we & sel),
    .wAddr     (w_addr),
    .wData     (w_data[15:0]),
    .rAddr0    (r_addr0),
    .rAddr1    (r_addr1),
    .rData0    (b_rdata0),
    .rData1    (b_rdata1),
    .rValid0   (b_rvalid0),
    .rValid1   (b_rvalid1),
    .clr_start (clr_start & sel),
    .busy      (b_busy),
    .wr_drop   (b_wr_drop)
  );

  assign obs_d0   = sel ? {16'h0, b_rdata0} : a_rdata0;
  assign obs_d1   = sel ? {16'h0, b_rdata1} : a_rdata1;
  assign obs_v0   = sel ? b_rvalid0 : a_rvalid0;
  assign obs_v1   = sel ? b_rvalid1 : a_rvalid1;
  assign obs_busy = sel ? b_busy : a_busy;
  assign obs_drop = sel ? b_wr_drop : a_wr_drop;

  function automatic int depth();
    return sel ? 16 : 8;
  endfunction

  function automatic logic [31:0] dmask();
    return sel ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_ptr  = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus: predict the registered read results from the model,
  // queue them, advance the model, then compare just after the edge.
  task automatic applyStimulus(input logic s_we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] ra0, input logic [3:0] ra1, input logic s_clr);
    int          am;
    rd_exp_t     e;
    rd_exp_t     got;
    logic        wr_ok;
    logic        exp_drop;
    int          a0, a1, aw;
    am = depth() - 1;
    aw = int'(wa) & am;
    a0 = int'(ra0) & am;
    a1 = int'(ra1) & am;
    wd = wd & dmask();
    we = s_we; w_addr = 4'(aw); w_data = wd;
    r_addr0 = 4'(a0); r_addr1 = 4'(a1); clr_start = s_clr;

    wr_ok = s_we && !m_busy;
    e.d0 = m_mem[a0]; e.v0 = m_val[a0];
    e.d1 = m_mem[a1]; e.v1 = m_val[a1];
    if (m_busy && m_ptr == a0) begin e.d0 = '0; e.v0 = 1'b0; end
    if (m_busy && m_ptr == a1) begin e.d1 = '0; e.v1 = 1'b0; end
    if (wr_ok && aw == a0) begin e.d0 = wd; e.v0 = 1'b1; end
    if (wr_ok && aw == a1) begin e.d1 = wd; e.v1 = 1'b1; end
    exp_q.push_back(e);
    exp_drop = s_we && m_busy;

    if (wr_ok) begin
      m_mem[aw] = wd;
      m_val[aw] = 1'b1;
    end
    if (m_busy) begin
      m_mem[m_ptr] = '0;
      m_val[m_ptr] = 1'b0;
      if (m_ptr == am) m_busy = 1'b0;
      m_ptr = (m_ptr + 1) & am;
    end else if (s_clr) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checkOutput(got, exp_drop);
    we = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic checkOutput(input rd_exp_t e, input logic exp_drop);
    check("rData0", obs_d0, e.d0);
    check("rValid0", 32'(obs_v0), 32'(e.v0));
    check("rData1", obs_d1, e.d1);
    check("rValid1", 32'(obs_v1), 32'(e.v1));
    check("busy", 32'(obs_busy), 32'(m_busy));
    check("wr_drop", 32'(obs_drop), 32'(exp_drop));
  endtask

  // Asserted just after an edge; outputs must clear before the next edge.
  task automatic applyReset();
    reset = 1'b1;
    #2;
    check("rst_rData0", obs_d0, 32'h0);
    check("rst_rData1", obs_d1, 32'h0);
    check("rst_rValid", {30'h0, obs_v1, obs_v0}, 32'h0);
    check("rst_busy", 32'(obs_busy), 32'h0);
    check("rst_wr_drop", 32'(obs_drop), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fillAll();
    for (int i = 0; i < depth(); i++)
      applyStimulus(1'b1, 4'(i), 32'h10 + 32'(i), 4'(i), 4'(i), 1'b0);
  endtask

  // Starts a sweep and counts the edges during which busy was high.
  task automatic runSweep(input logic with_drop);
    int cnt;
    int guard;
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd7, 4'd0, 1'b1);
    check("busy_rise", 32'(obs_busy), 32'h1);
    applyStimulus(with_drop, 4'd2, 32'h55, 4'd7, 4'd0, with_drop);
    cnt = 1;
    check("mid_addr7", obs_d0, 32'h17);
    check("mid_addr0", {obs_d1[30:0], obs_v1}, 32'h0);
    if (with_drop) begin
      check("wr_drop_pulse", 32'(obs_drop), 32'h1);
      applyStimulus(1'b0, 4'd0, 32'h0, 4'd2, 4'd7, 1'b0);
      cnt++;
      check("drop_entry2", obs_d0, 32'h12);
    end
    guard = 0;
    while (obs_busy && guard < 64) begin
      applyStimulus(1'b0, 4'd0, 32'h0, 4'(guard), 4'd7, 1'b0);
      cnt++;
      guard++;
    end
    check("busy_cycles", 32'(cnt), 32'(depth()));
    for (int i = 0; i < depth(); i++)
      applyStimulus(1'b0, 4'd0, 32'h0, 4'(i), 4'(depth() - 1 - i), 1'b0);
    check("post_sweep_valid", {30'h0, obs_v1, obs_v0}, 32'h0);
  endtask

  task automatic runBasic();
    applyReset();
    for (int i = 0; i < depth(); i++)
      applyStimulus(1'b0, 4'd0, 32'h0, 4'(i), 4'(depth() - 1 - i), 1'b0);
    applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, 4'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd3, 4'd5, 1'b0);
    check("rd_addr3", obs_d0, 32'hDEADBEEF & dmask());
    check("rd_addr3_valid", 32'(obs_v0), 32'h1);
    check("rd_addr5", {obs_d1[30:0], obs_v1}, 32'h0);
    applyStimulus(1'b1, 4'd6, 32'h12345678, 4'd6, 4'd6, 1'b0);
    check("bypass_p0", obs_d0, 32'h12345678 & dmask());
    check("bypass_p1", obs_d1, 32'h12345678 & dmask());
    check("bypass_valid", {30'h0, obs_v1, obs_v0}, 32'h3);
    fillAll();
    runSweep(1'b0);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;

    sel = 1'b0;
    runBasic();

    fillAll();
    runSweep(1'b1);

    fillAll();
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd7, 4'd6, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 4'd0, 32'h0, 4'd7, 4'd6, 1'b0);
    check("pre_reset_data", obs_d0, 32'h17);
    applyReset();
    applyStimulus(1'b1, 4'd1, 32'hCAFE0001, 4'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd1, 4'd1, 1'b0);
    check("post_reset_write", obs_d1, 32'hCAFE0001);

    sel = 1'b1;
    runBasic();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised register file with one write port and two independent read ports.
- Reads are registered (1-cycle latency) with write-first bypass.
- Each entry carries a valid bit.
- A sequencer clears all entries, one per cycle, on request.
- Serves as the storage core for the next-generation FIFO and for datapath blocks that need two operands per cycle.

Parameters:
- DATA_WIDTH, 32, width of each entry.
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH entries (local, not overridable).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  write enable.
- wAddr  input  ADDR_WIDTH  write address.
- wData  input  DATA_WIDTH  write data.
- rAddr0  input  ADDR_WIDTH  read port 0 address.
- rAddr1  input  ADDR_WIDTH  read port 1 address.
- rData0  output  DATA_WIDTH  read port 0 data, registered.
- rData1  output  DATA_WIDTH  read port 1 data, registered.
- rValid0  output  1  valid bit of the entry read on port 0, registered.
- rValid1  output  1  valid bit of the entry read on port 1, registered.
- clr_start  input  1  one-cycle request to start a clear sweep.
- busy  output  1  clear sweep in progress.
- wr_drop  output  1  one-cycle pulse when a write is discarded because busy=1.

Behaviour:
- Reset (asynchronous, active-high), takes effect immediately:
  - all DEPTH entries = 0, all valid bits = 0;
  - rData0/1 = 0, rValid0/1 = 0, busy = 0, wr_drop = 0;
  - FSM = IDLE, clear pointer = 0.
- Write:
  - on a rising edge with we=1 and busy=0: mem[wAddr] <= wData and valid[wAddr] <= 1.
  - with we=1 and busy=1: no array change, wr_drop=1 for the following cycle; otherwise wr_drop=0.
- Read:
  - each edge, rDataN <= mem[rAddrN] and rValidN <= valid[rAddrN]. Latency is 1 cycle, no enable.
  - Both ports may read the same address in the same cycle; the results are identical.
- Bypass (write-first): if an accepted write in the same cycle has wAddr == rAddrN, then rDataN <= wData and rValidN <= 1. This applies to both ports independently.
- Clear FSM:
  - IDLE:
    - clr_start=1 -> CLEAR with pointer=0 and busy=1 from the next cycle.
    - A write accepted in the same cycle as clr_start is performed; the sweep erases it later.
  - CLEAR:
    - each cycle, mem[pointer] <= 0, valid[pointer] <= 0, pointer <= pointer+1.
    - When pointer == DEPTH-1: clear that entry, return to IDLE, busy=0 from the next cycle.
    - busy is high for exactly DEPTH cycles.
    - clr_start while busy is ignored; the sweep is not restarted.
    - During CLEAR, reads return current array contents: entries already swept read 0 / valid 0, unswept entries read their old values.
    - A read of the entry being cleared in that cycle returns 0 / valid 0 (clear-first bypass).
- Pointer arithmetic: ADDR_WIDTH bits, wraps naturally. Termination is decided by comparison with DEPTH-1, not by overflow.
- Reset asserted mid-sweep: sweep aborts immediately, all state goes to reset values, busy=0.
- Data width: no truncation or extension; wData is stored bit-exact.

Test Plan:
1. Reset then read every address on both ports -> rData0/1=0, rValid0/1=0, busy=0.
2. Write addr 3 = 0xDEADBEEF, next cycle rAddr0=3, rAddr1=5 -> one edge later rData0=0xDEADBEEF with rValid0=1; rData1=0 with rValid1=0.
3. Same-cycle bypass: we=1, wAddr=6, wData=0x12345678, rAddr0=rAddr1=6 -> after that edge both ports give 0x12345678 with valid=1.
4. Clear sweep (defaults):
   - fill all 8 entries with 0x10+i;
   - pulse clr_start -> busy high for exactly 8 cycles;
   - mid-sweep, reading addr 7 gives 0x17 while addr 0 gives 0 / valid 0;
   - after busy falls, all entries read 0 / valid 0.
5. Write during busy: we=1, wAddr=2 while busy -> wr_drop=1 next cycle, entry 2 unchanged; a second clr_start during busy does not extend busy beyond 8 cycles.
6. Assert reset at sweep cycle 4 -> busy=0 and all outputs 0 immediately. After release, a write to addr 1 is accepted and reads back correctly.
7. Parameter override: DATA_WIDTH=16, ADDR_WIDTH=4 -> repeat tests 2–4 with 16 entries and a 16-cycle busy.
